// File: rtl/plug_pkg.sv
// Shared types and default timing for the Propeller host transmitter.
package plug_pkg;

  // 115200 baud at a 160 MHz clock.
  localparam int BAUD_DIV_DEFAULT = 1389;
  // 100 us reset pulse at 160 MHz.
  localparam int RST_CYCLES_DEFAULT = 16000;
  // 100 ms boot wait at 160 MHz.
  localparam int BOOT_CYCLES_DEFAULT = 16000000;

  localparam int BAUD_W = 16;
  localparam int DELAY_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    RST_LO,
    RST_WAIT,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/plug_baud_tick.sv
// Reloadable bit-period down-counter. A load starts a fresh period; while
// enabled the counter wraps on its own and flags the last cycle of each bit.
module plug_baud_tick
  import plug_pkg::*;
#(
  parameter int DIV = BAUD_DIV_DEFAULT
) (
  input  logic clock_160,
  input  logic inp_resn,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam logic [BAUD_W-1:0] RELOAD = BAUD_W'(DIV - 1);

  logic [BAUD_W-1:0] count;

  // Count down once per cycle and restart the period on load or at zero.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en) begin
      if (count == '0) begin
        count <= RELOAD;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign tick = en && (count == '0);

endmodule

// File: rtl/plug_host_tx.sv
// Host-side link to a Parallax Propeller: 8N1 UART transmitter on plug_tx
// plus an optional reset/boot sequencer on plug_resn.
// Build option: define PLUG_RESET_EN to include the reset pulse, the boot
// wait, the pending-boot flag and the delay counter. Without it boot_req is
// ignored and plug_resn is tied high.
module plug_host_tx
  import plug_pkg::*;
#(
  parameter int BAUD_DIV    = BAUD_DIV_DEFAULT,
  parameter int RST_CYCLES  = RST_CYCLES_DEFAULT,
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEFAULT
) (
  input  logic       clock_160,
  input  logic       inp_resn,
  input  logic       boot_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       plug_tx,
  output logic       plug_resn,
  output logic       busy
);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       accept;
  logic       in_frame;
  logic       tick;

  // The handshake completes on the edge where both sides are high in IDLE.
  assign accept   = (state == IDLE) && tx_valid && tx_ready;
  assign in_frame = (state == START) || (state == DATA) || (state == STOP);

  plug_baud_tick #(
    .DIV(BAUD_DIV)
  ) u_baud (
    .clock_160(clock_160),
    .inp_resn (inp_resn),
    .load     (accept),
    .en       (in_frame),
    .tick     (tick)
  );

`ifdef PLUG_RESET_EN

  localparam logic [DELAY_W-1:0] RST_LOAD  = DELAY_W'(RST_CYCLES - 1);
  localparam logic [DELAY_W-1:0] BOOT_LOAD = DELAY_W'(BOOT_CYCLES - 1);

  logic               pending;
  logic [DELAY_W-1:0] delay;

  // Main sequencer: frames bytes and runs the reset pulse and boot wait.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      state     <= IDLE;
      plug_tx   <= 1'b1;
      plug_resn <= 1'b1;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      pending   <= 1'b0;
      delay     <= '0;
      shift     <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            plug_tx  <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            shift    <= tx_data;
            bit_idx  <= '0;
            pending  <= boot_req;
          end else if (boot_req) begin
            state     <= RST_LO;
            plug_resn <= 1'b0;
            tx_ready  <= 1'b0;
            busy      <= 1'b1;
            delay     <= RST_LOAD;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        START: begin
          if (boot_req) begin
            pending <= 1'b1;
          end
          if (tick) begin
            state   <= DATA;
            plug_tx <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (boot_req) begin
            pending <= 1'b1;
          end
          if (tick) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              plug_tx <= 1'b1;
            end else begin
              plug_tx <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (boot_req) begin
            pending <= 1'b1;
          end
          if (tick) begin
            if (pending || boot_req) begin
              state     <= RST_LO;
              plug_resn <= 1'b0;
              pending   <= 1'b0;
              delay     <= RST_LOAD;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end
          end
        end

        RST_LO: begin
          if (delay == '0) begin
            state     <= RST_WAIT;
            plug_resn <= 1'b1;
            delay     <= BOOT_LOAD;
          end else begin
            delay <= delay - 1'b1;
          end
        end

        RST_WAIT: begin
          if (delay == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
          end else begin
            delay <= delay - 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          plug_tx   <= 1'b1;
          plug_resn <= 1'b1;
          tx_ready  <= 1'b0;
          busy      <= 1'b0;
          pending   <= 1'b0;
        end
      endcase
    end
  end

`else

  logic unused_cfg;

  assign unused_cfg = ^{boot_req, RST_CYCLES, BOOT_CYCLES};
  assign plug_resn  = 1'b1;

  // UART-only sequencer: frames bytes, boot requests have no effect.
  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      state    <= IDLE;
      plug_tx  <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            plug_tx  <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            shift    <= tx_data;
            bit_idx  <= '0;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            state   <= DATA;
            plug_tx <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              plug_tx <= 1'b1;
            end else begin
              plug_tx <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          plug_tx  <= 1'b1;
          tx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_plug_host_tx.sv
// Bench for plug_host_tx with short timing (BAUD_DIV=4, RST_CYCLES=8,
// BOOT_CYCLES=20). Follows PLUG_RESET_EN the same way the design does.
module tb_plug_host_tx;

  localparam int BAUD = 4;
  localparam int RSTC = 8;
  localparam int BOOTC = 20;
  localparam int FRAME = 10 * BAUD;

  logic       clock_160 = 1'b0;
  logic       inp_resn;
  logic       boot_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       plug_tx;
  logic       plug_resn;
  logic       busy;

  int   compared = 0;
  int   mismatched = 0;
  logic exp_q[$];

  plug_host_tx #(
    .BAUD_DIV   (BAUD),
    .RST_CYCLES (RSTC),
    .BOOT_CYCLES(BOOTC)
  ) dut (
    .clock_160(clock_160),
    .inp_resn (inp_resn),
    .boot_req (boot_req),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .plug_tx  (plug_tx),
    .plug_resn(plug_resn),
    .busy     (busy)
  );

  always #5 clock_160 = ~clock_160;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Pushes the per-cycle expected plug_tx levels of an 8N1 frame and drives the byte.
  task automatic applyStimulus(input logic [7:0] data);
    logic lvl;
    for (int b = 0; b < 10; b++) begin
      if (b == 0) lvl = 1'b0;
      else if (b == 9) lvl = 1'b1;
      else lvl = data[b-1];
      for (int k = 0; k < BAUD; k++) exp_q.push_back(lvl);
    end
    tx_data  = data;
    tx_valid = 1'b1;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clock_160);
      n++;
    end
    checkOutput("wait_tx_ready", tx_ready, 1'b1);
  endtask

  task automatic runFrame(input logic [7:0] data, input int boot_at, input int boot_at2,
                          input int abort_at);
    logic e;
    waitReady();
    applyStimulus(data);
    if (boot_at == 0) boot_req = 1'b1;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clock_160);
      tx_valid = 1'b0;
      boot_req = 1'b0;
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_empty", 1'b1, 1'b0);
        e = 1'b1;
      end else begin
        e = exp_q.pop_front();
      end
      checkOutput("frame_plug_tx", plug_tx, e);
      checkOutput("frame_tx_ready", tx_ready, 1'b0);
      checkOutput("frame_busy", busy, 1'b1);
      checkOutput("frame_plug_resn", plug_resn, 1'b1);
      if (c == boot_at || c == boot_at2) boot_req = 1'b1;
      if (c == abort_at) begin
        inp_resn = 1'b0;
        #1;
        checkOutput("abort_plug_tx", plug_tx, 1'b1);
        checkOutput("abort_plug_resn", plug_resn, 1'b1);
        checkOutput("abort_tx_ready", tx_ready, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic checkIdleAfterFrame();
    @(negedge clock_160);
    checkOutput("end_tx_ready", tx_ready, 1'b1);
    checkOutput("end_busy", busy, 1'b0);
    checkOutput("end_plug_tx", plug_tx, 1'b1);
  endtask

`ifdef PLUG_RESET_EN
  // Walks the reset pulse and boot wait, injecting boot_req pulses that must be ignored.
  task automatic checkBootSeq();
    for (int c = 1; c <= RSTC + BOOTC; c++) begin
      @(negedge clock_160);
      boot_req = 1'b0;
      checkOutput("seq_plug_resn", plug_resn, (c <= RSTC) ? 1'b0 : 1'b1);
      checkOutput("seq_busy", busy, 1'b1);
      checkOutput("seq_tx_ready", tx_ready, 1'b0);
      checkOutput("seq_plug_tx", plug_tx, 1'b1);
      if (c == 3 || c == RSTC + 5) boot_req = 1'b1;
    end
    @(negedge clock_160);
    boot_req = 1'b0;
    checkOutput("seq_end_busy", busy, 1'b0);
    checkOutput("seq_end_tx_ready", tx_ready, 1'b1);
    checkOutput("seq_end_plug_resn", plug_resn, 1'b1);
  endtask
`endif

  initial begin
    inp_resn = 1'b1;
    boot_req = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    #1 inp_resn = 1'b0;
    repeat (3) @(negedge clock_160);
    checkOutput("reset_plug_tx", plug_tx, 1'b1);
    checkOutput("reset_plug_resn", plug_resn, 1'b1);
    checkOutput("reset_tx_ready", tx_ready, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);

    inp_resn = 1'b1;
    @(negedge clock_160);
    checkOutput("release_tx_ready", tx_ready, 1'b1);

    $display("[TB] frame 0xA5 then back-to-back 0x5A");
    runFrame(8'hA5, -1, -1, -1);
    checkIdleAfterFrame();
    runFrame(8'h5A, -1, -1, -1);
    checkIdleAfterFrame();

`ifdef PLUG_RESET_EN
    $display("[TB] boot request in IDLE");
    boot_req = 1'b1;
    checkBootSeq();

    $display("[TB] boot requests during data bit 3 of 0x00");
    runFrame(8'h00, 18, 30, -1);
    checkBootSeq();

    $display("[TB] boot request together with accepted byte");
    runFrame(8'hC3, 0, -1, -1);
    checkBootSeq();

    $display("[TB] reset during RST_LO");
    boot_req = 1'b1;
    @(negedge clock_160);
    boot_req = 1'b0;
    @(negedge clock_160);
    checkOutput("rstlo_plug_resn", plug_resn, 1'b0);
    inp_resn = 1'b0;
    #1;
    checkOutput("rstlo_abort_plug_resn", plug_resn, 1'b1);
    checkOutput("rstlo_abort_busy", busy, 1'b0);
    @(negedge clock_160);
    inp_resn = 1'b1;
    @(negedge clock_160);
    checkOutput("rstlo_release_tx_ready", tx_ready, 1'b1);
`else
    $display("[TB] boot request ignored in UART-only build");
    boot_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock_160);
      boot_req = 1'b0;
      checkOutput("noboot_plug_resn", plug_resn, 1'b1);
      checkOutput("noboot_busy", busy, 1'b0);
      checkOutput("noboot_tx_ready", tx_ready, 1'b1);
    end
`endif

    $display("[TB] reset during data bit 5, then 0x3C");
    runFrame(8'h00, -1, -1, 26);
    repeat (2) @(negedge clock_160);
    inp_resn = 1'b1;
    @(negedge clock_160);
    checkOutput("abort_release_tx_ready", tx_ready, 1'b1);
    runFrame(8'h3C, -1, -1, -1);
    checkIdleAfterFrame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
